// File: rtl/fp16_pkg.sv
// Shared bfloat16-style number model: field layout, FSM state type, field helpers.
// FDIV_ROUND_EN adds guard/round quotient bits for round-to-nearest-even.
package fp16_pkg;
  localparam int M_W   = 7;
  localparam int EXP_W = 8;
  localparam int W     = 1 + EXP_W + M_W;
  localparam int BIAS  = 127;
  localparam logic [EXP_W-1:0] EXP_ALL1 = '1;

  // Quotient bits: 1 integer bit + M_W+1 fraction bits, plus guard/round when rounding
`ifdef FDIV_ROUND_EN
  localparam int NQ = M_W + 4;
`else
  localparam int NQ = M_W + 2;
`endif

  typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} fdiv_state_t;

  function automatic logic f_sign(input logic [W-1:0] x);
    return x[W-1];
  endfunction

  function automatic logic [EXP_W-1:0] f_exp(input logic [W-1:0] x);
    return x[W-2 -: EXP_W];
  endfunction

  function automatic logic [M_W-1:0] f_mant(input logic [W-1:0] x);
    return x[M_W-1:0];
  endfunction
endpackage

// File: rtl/fdiv_seq_if.sv
// Operand/result handshake bundle for the sequential divider.
interface fdiv_seq_if;
  logic                   in_valid;
  logic                   in_ready;
  logic [fp16_pkg::W-1:0] a_in;
  logic [fp16_pkg::W-1:0] b_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [fp16_pkg::W-1:0] result;

  modport master (output in_valid, a_in, b_in, out_ready,
                  input  in_ready, out_valid, result);
  modport slave  (input  in_valid, a_in, b_in, out_ready,
                  output in_ready, out_valid, result);
endinterface

// File: rtl/fdiv_norm_round.sv
// Combinational back end: normalise raw quotient, optional RNE rounding, exponent saturation.
// Rounding is compiled in only with FDIV_ROUND_EN.
module fdiv_norm_round
  import fp16_pkg::*;
(
  input  logic [NQ-1:0]     q,
  input  logic              sticky,
  input  logic              sign,
  input  logic signed [9:0] exp_diff,
  output logic [W-1:0]      result
);
  logic [M_W-1:0]    mant_raw;
  logic [M_W-1:0]    mant_fin;
  logic signed [9:0] exp_n;
`ifdef FDIV_ROUND_EN
  localparam int RB = NQ - M_W - 2;
  logic           guard;
  logic           rest;
  logic [M_W:0]   mant_r;
`else
  logic unused_sticky;
  assign unused_sticky = sticky;
`endif

  always_comb begin
    // q lies in (0.5,2): either the integer bit or the first fraction bit leads
    if (q[NQ-1]) begin
      mant_raw = q[NQ-2 -: M_W];
      exp_n    = exp_diff + 10'sd127;
    end else begin
      mant_raw = q[NQ-3 -: M_W];
      exp_n    = exp_diff + 10'sd126;
    end
    mant_fin = mant_raw;
`ifdef FDIV_ROUND_EN
    guard  = q[NQ-1] ? q[RB] : q[RB-1];
    rest   = q[NQ-1] ? (|q[RB-1:0]) : (|q[RB-2:0]);
    mant_r = {1'b0, mant_raw} + {{M_W{1'b0}}, guard & (rest | sticky | mant_raw[0])};
    mant_fin = mant_r[M_W-1:0];
    if (mant_r[M_W]) exp_n = exp_n + 10'sd1;
`endif
    if (exp_n >= 10'sd255)
      result = {sign, EXP_ALL1, {M_W{1'b0}}};
    else if (exp_n <= 10'sd0)
      result = {sign, {(W-1){1'b0}}};
    else
      result = {sign, exp_n[EXP_W-1:0], mant_fin};
  end
endmodule

// File: rtl/fdiv_seq.sv
// Multi-cycle bfloat16 divider: one restoring shift-subtract quotient bit per clock.
// Build option FDIV_ROUND_EN: two extra quotient bits and round-to-nearest-even.
module fdiv_seq
  import fp16_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  fdiv_seq_if.slave  io
);
  fdiv_state_t       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [M_W:0]      rem_q, rem_d;
  logic [M_W:0]      div_q, div_d;
  logic [NQ-1:0]     quo_q, quo_d;
  logic              sign_q, sign_d;
  logic signed [9:0] ediff_q, ediff_d;
  logic [W-1:0]      result_q, result_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;

  logic [M_W+1:0]    rem2, rem_sub;
  logic              qbit;
  logic [W-1:0]      norm_res;

  fdiv_norm_round u_norm (
    .q        (quo_q),
    .sticky   (|rem_q),
    .sign     (sign_q),
    .exp_diff (ediff_q),
    .result   (norm_res)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    div_d    = div_q;
    quo_d    = quo_q;
    sign_d   = sign_q;
    ediff_d  = ediff_q;
    result_d = result_q;

    // First step compares the loaded mantissa unshifted to produce the integer bit
    rem2    = (cnt_q == 4'd0) ? {1'b0, rem_q} : {rem_q, 1'b0};
    qbit    = (rem2 >= {1'b0, div_q});
    rem_sub = qbit ? (rem2 - {1'b0, div_q}) : rem2;

    case (state_q)
      IDLE: if (io.in_valid) begin
        sign_d = f_sign(io.a_in) ^ f_sign(io.b_in);
        if (f_exp(io.b_in) == '0) begin
          result_d = {sign_d, EXP_ALL1, {M_W{1'b0}}};
          state_d  = DONE;
        end else if (f_exp(io.a_in) == '0) begin
          result_d = {sign_d, {(W-1){1'b0}}};
          state_d  = DONE;
        end else begin
          rem_d   = {1'b1, f_mant(io.a_in)};
          div_d   = {1'b1, f_mant(io.b_in)};
          cnt_d   = 4'd0;
          quo_d   = '0;
          ediff_d = $signed({2'b00, f_exp(io.a_in)}) - $signed({2'b00, f_exp(io.b_in)});
          state_d = CALC;
        end
      end
      CALC: begin
        rem_d = rem_sub[M_W:0];
        quo_d = {quo_q[NQ-2:0], qbit};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(NQ-1)) state_d = NORM;
      end
      NORM: begin
        result_d = norm_res;
        state_d  = DONE;
      end
      DONE: if (io.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      div_q       <= '0;
      quo_q       <= '0;
      sign_q      <= 1'b0;
      ediff_q     <= '0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      div_q       <= div_d;
      quo_q       <= quo_d;
      sign_q      <= sign_d;
      ediff_q     <= ediff_d;
      result_q    <= result_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.result    = result_q;
endmodule

// File: tb/tb_fdiv_seq.sv
// Directed-vector bench for fdiv_seq; expectations hand-derived from the divider's number model.
module tb_fdiv_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vecs = 0;
  int   errs = 0;

`ifdef FDIV_ROUND_EN
  localparam int          LAT       = 13;
  localparam logic [15:0] ONE_THIRD = 16'h3EAB;
`else
  localparam int          LAT       = 11;
  localparam logic [15:0] ONE_THIRD = 16'h3EAA;
`endif

  fdiv_seq_if io ();

  fdiv_seq u_dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  always #5 clk = ~clk;

  // Drives one operation and returns the result and accept-to-valid latency in edges.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] res, output int lat);
    @(negedge clk);
    io.a_in = a; io.b_in = b; io.in_valid = 1'b1;
    @(posedge clk);
    #1 io.in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!io.out_valid && lat < 40) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    res = io.result;
  endtask

  task automatic take_result();
    @(negedge clk); io.out_ready = 1'b1;
    @(posedge clk); #1 io.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vecs++; if (io.in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got %b want 1", io.in_ready); end
    vecs++; if (io.out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got %b want 0", io.out_valid); end
    vecs++; if (io.result !== 16'h0) begin errs++; $display("FAIL reset_result got %h want 0000", io.result); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [15:0] r; int l;
    run_op(16'h4040, 16'h4000, r, l);
    vecs++; if (r !== 16'h3FC0) begin errs++; $display("FAIL basic_3div2 got %h want 3fc0", r); end
    vecs++; if (l !== LAT) begin errs++; $display("FAIL basic_latency got %0d want %0d", l, LAT); end
    take_result();
  endtask

  task automatic test_rounding();
    logic [15:0] r; int l;
    run_op(16'h3F80, 16'h4040, r, l);
    vecs++; if (r !== ONE_THIRD) begin errs++; $display("FAIL round_1div3 got %h want %h", r, ONE_THIRD); end
    take_result();
  endtask

  task automatic test_sign_scale();
    logic [15:0] r; int l;
    run_op(16'hC000, 16'h3F00, r, l);
    vecs++; if (r !== 16'hC080) begin errs++; $display("FAIL sign_scale got %h want c080", r); end
    vecs++; if (l !== LAT) begin errs++; $display("FAIL sign_scale_latency got %0d want %0d", l, LAT); end
    take_result();
  endtask

  task automatic test_special();
    logic [15:0] va [3] = '{16'h3F80, 16'hBF80, 16'h0000};
    logic [15:0] vb [3] = '{16'h0000, 16'h0000, 16'h4000};
    logic [15:0] ve [3] = '{16'h7F80, 16'hFF80, 16'h0000};
    logic [15:0] r; int l;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], r, l);
      vecs++; if (r !== ve[i]) begin errs++; $display("FAIL special_%0d got %h want %h", i, r, ve[i]); end
      vecs++; if (l !== 1) begin errs++; $display("FAIL special_%0d_latency got %0d want 1", i, l); end
      take_result();
    end
  endtask

  task automatic test_saturation();
    logic [15:0] r; int l;
    run_op(16'h7F00, 16'h0080, r, l);
    vecs++; if (r !== 16'h7F80) begin errs++; $display("FAIL sat_overflow got %h want 7f80", r); end
    take_result();
    run_op(16'h0080, 16'h7F00, r, l);
    vecs++; if (r !== 16'h0000) begin errs++; $display("FAIL sat_underflow got %h want 0000", r); end
    take_result();
  endtask

  task automatic test_hold();
    logic [15:0] r; int l;
    run_op(16'h4040, 16'h4000, r, l);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vecs++; if (io.result !== 16'h3FC0 || io.out_valid !== 1'b1 || io.in_ready !== 1'b0) begin
        errs++; $display("FAIL hold_%0d got res=%h ov=%b ir=%b want 3fc0/1/0", i, io.result, io.out_valid, io.in_ready);
      end
    end
    take_result();
    #1;
    vecs++; if (io.in_ready !== 1'b1) begin errs++; $display("FAIL hold_release_in_ready got %b want 1", io.in_ready); end
  endtask

  task automatic test_busy();
    int l;
    @(negedge clk);
    io.a_in = 16'h4040; io.b_in = 16'h4000; io.in_valid = 1'b1;
    @(posedge clk);
    #1 io.a_in = 16'h3F80; io.b_in = 16'h4040;
    l = 1;
    @(negedge clk);
    while (!io.out_valid && l < 40) begin
      vecs++; if (io.in_ready !== 1'b0) begin errs++; $display("FAIL busy_in_ready_%0d got %b want 0", l, io.in_ready); end
      io.in_valid = ~io.in_valid;
      @(posedge clk); l++; @(negedge clk);
    end
    io.in_valid = 1'b0;
    vecs++; if (io.result !== 16'h3FC0) begin errs++; $display("FAIL busy_result got %h want 3fc0", io.result); end
    vecs++; if (l !== LAT) begin errs++; $display("FAIL busy_latency got %0d want %0d", l, LAT); end
    take_result();
  endtask

  task automatic test_reset_mid();
    logic [15:0] r; int l;
    @(negedge clk);
    io.a_in = 16'h4040; io.b_in = 16'h4000; io.in_valid = 1'b1;
    @(posedge clk);
    #1 io.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    vecs++; if (io.in_ready !== 1'b1 || io.out_valid !== 1'b0 || io.result !== 16'h0) begin
      errs++; $display("FAIL rst_mid got ir=%b ov=%b res=%h want 1/0/0000", io.in_ready, io.out_valid, io.result);
    end
    @(negedge clk); rst = 1'b0;
    run_op(16'hC000, 16'h3F00, r, l);
    vecs++; if (r !== 16'hC080) begin errs++; $display("FAIL rst_mid_recover got %h want c080", r); end
    take_result();
  endtask

  task automatic test_back_to_back();
    logic [15:0] r; int l;
    run_op(16'h3F80, 16'h4040, r, l);
    vecs++; if (r !== ONE_THIRD) begin errs++; $display("FAIL b2b_first got %h want %h", r, ONE_THIRD); end
    take_result();
    run_op(16'h4040, 16'h4000, r, l);
    vecs++; if (r !== 16'h3FC0) begin errs++; $display("FAIL b2b_second got %h want 3fc0", r); end
    vecs++; if (l !== LAT) begin errs++; $display("FAIL b2b_latency got %0d want %0d", l, LAT); end
    take_result();
  endtask

  initial begin
    io.in_valid  = 1'b0;
    io.out_ready = 1'b0;
    io.a_in      = '0;
    io.b_in      = '0;
    test_reset();
    test_basic();
    test_rounding();
    test_sign_scale();
    test_special();
    test_saturation();
    test_hold();
    test_busy();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
